// File: rtl/obuffer4_if.sv
// Handshake bundle between the MAC-array result side and the de-skewing row buffer.
// The buffer itself connects through the slave modport; the producer/consumer side uses master.
interface obuffer4_if;
    logic [3:0]  OCOL_VALID;
    logic [31:0] OROW_i;
    logic [3:0]  ODST_i;
    logic        OREADY;
    logic [31:0] OWord;
    logic        OVALID;
    logic [1:0]  OADDR;
    logic [3:0]  ODST_o;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    modport master (
        output OCOL_VALID, OROW_i, ODST_i, OREADY,
        input  OWord, OVALID, OADDR, ODST_o, BUSY, DONE, ERR
    );

    modport slave (
        input  OCOL_VALID, OROW_i, ODST_i, OREADY,
        output OWord, OVALID, OADDR, ODST_o, BUSY, DONE, ERR
    );
endinterface

// File: rtl/obuffer4.sv
// De-skewing output buffer: collects four column-skewed result streams into a 4x4 byte
// matrix, then drains it row by row over a valid/ready handshake.
module obuffer4 (
    input  logic       CLK,
    input  logic       RSTN,
    obuffer4_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t      r_state;
    logic [7:0]  r_mem [0:3][0:3];
    logic [1:0]  r_cnt [0:3];
    logic [3:0]  r_full;
    logic [31:0] r_oword;
    logic        r_ovalid;
    logic [1:0]  r_oaddr;
    logic [3:0]  r_odst;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [1:0]  w_row_nxt;
    logic [31:0] w_word_row0;
    logic [31:0] w_word_nxt;
    logic        w_last_col3;

    // Byte lane j of a row word; lane 0 sits in the top byte.
    function automatic logic [7:0] lane(input logic [31:0] w, input int j);
        lane = w[31-8*j -: 8];
    endfunction

    assign w_row_nxt   = r_oaddr + 2'd1;
    assign w_word_row0 = {r_mem[0][0], r_mem[0][1], r_mem[0][2], r_mem[0][3]};
    assign w_word_nxt  = {r_mem[w_row_nxt][0], r_mem[w_row_nxt][1],
                          r_mem[w_row_nxt][2], r_mem[w_row_nxt][3]};
    // Column 3 taking its 4th beat closes the matrix; row 0 is already complete by then.
    assign w_last_col3 = bus.OCOL_VALID[3] && !r_full[3] && (r_cnt[3] == 2'd3);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state  <= ST_IDLE;
            r_full   <= 4'd0;
            r_oword  <= 32'd0;
            r_ovalid <= 1'b0;
            r_oaddr  <= 2'd0;
            r_odst   <= 4'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            for (int j = 0; j < 4; j++) begin
                r_cnt[j] <= 2'd0;
                for (int i = 0; i < 4; i++) begin
                    r_mem[i][j] <= 8'd0;
                end
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|bus.OCOL_VALID[3:1]) begin
                        r_err <= 1'b1;
                    end
                    if (bus.OCOL_VALID[0]) begin
                        r_mem[r_cnt[0]][0] <= lane(bus.OROW_i, 0);
                        r_cnt[0]           <= r_cnt[0] + 2'd1;
                        r_odst             <= bus.ODST_i;
                        r_busy             <= 1'b1;
                        r_state            <= ST_CAPTURE;
                    end
                end

                ST_CAPTURE: begin
                    for (int j = 0; j < 4; j++) begin
                        if (bus.OCOL_VALID[j]) begin
                            if (r_full[j]) begin
                                r_err <= 1'b1;
                            end else begin
                                r_mem[r_cnt[j]][j] <= lane(bus.OROW_i, j);
                                r_cnt[j]           <= r_cnt[j] + 2'd1;
                                if (r_cnt[j] == 2'd3) begin
                                    r_full[j] <= 1'b1;
                                end
                            end
                        end
                    end
                    if (w_last_col3) begin
                        r_state  <= ST_DRAIN;
                        r_ovalid <= 1'b1;
                        r_oaddr  <= 2'd0;
                        r_oword  <= w_word_row0;
                    end
                end

                ST_DRAIN: begin
                    // Inputs are never written here; a late col0 beat on the final handshake is an error too.
                    if (|bus.OCOL_VALID) begin
                        r_err <= 1'b1;
                    end
                    if (r_ovalid && bus.OREADY) begin
                        if (r_oaddr == 2'd3) begin
                            r_state  <= ST_IDLE;
                            r_ovalid <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_full   <= 4'd0;
                            for (int j = 0; j < 4; j++) begin
                                r_cnt[j] <= 2'd0;
                            end
                        end else begin
                            r_oaddr <= w_row_nxt;
                            r_oword <= w_word_nxt;
                        end
                    end
                end

                default: begin
                    r_state  <= ST_IDLE;
                    r_ovalid <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.OWord  = r_oword;
    assign bus.OVALID = r_ovalid;
    assign bus.OADDR  = r_oaddr;
    assign bus.ODST_o = r_odst;
    assign bus.BUSY   = r_busy;
    assign bus.DONE   = r_done;
    assign bus.ERR    = r_err;

endmodule

// File: tb/tb_obuffer4.sv
// Bench for obuffer4: table of matrix scenarios plus hand-written reset and idle-error sequences,
// with a row scoreboard checked on every output handshake.
module tb_obuffer4;

    logic CLK = 1'b0;
    logic RSTN = 1'b1;
    always #5 CLK = ~CLK;

    obuffer4_if bus();

    obuffer4 dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .bus  (bus)
    );

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] word;
        logic [3:0]  dst;
    } row_t;

    typedef struct {
        logic [7:0] base;
        logic [3:0] dst;
        int         stall_row;
        int         stall_len;
        bit         overrun;
        int         intrude_row;
        logic       exp_err;
    } vec_t;

    row_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [7:0] base, input int r);
        logic [31:0] w;
        w = 32'd0;
        for (int c = 0; c < 4; c++) begin
            w[31-8*c -: 8] = base + 8'(16*r + c);
        end
        return w;
    endfunction

    always @(negedge CLK) begin
        row_t e;
        if (RSTN && bus.OVALID === 1'b1 && bus.OREADY === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_row: got addr=%0d word=%h, expected no row", bus.OADDR, bus.OWord);
            end else begin
                e = sb.pop_front();
                check("row_addr_dst_word", {26'd0, bus.OADDR, bus.ODST_o, bus.OWord},
                      {26'd0, e.addr, e.dst, e.word});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {22'd0, bus.OWord, bus.OVALID, bus.OADDR, bus.ODST_o, bus.BUSY, bus.DONE, bus.ERR},
              64'd0);
    endtask

    task automatic apply_reset();
        bus.OCOL_VALID = 4'd0;
        bus.OROW_i     = 32'd0;
        bus.ODST_i     = 4'd0;
        bus.OREADY     = 1'b1;
        RSTN = 1'b0;
        #2;
        check_all_zero("reset_outputs");
        tick();
        tick();
        RSTN = 1'b1;
        tick();
    endtask

    task automatic send_beats(input vec_t v);
        logic [3:0]  vm;
        logic [31:0] d;
        int rr;
        for (int r = 0; r < 4; r++) begin
            sb.push_back('{addr: 2'(r), word: exp_word(v.base, r), dst: v.dst});
        end
        bus.ODST_i = v.dst;
        for (int t = 0; t < 7; t++) begin
            vm = 4'd0;
            d  = 32'd0;
            for (int j = 0; j < 4; j++) begin
                rr = t - j;
                if (rr >= 0 && rr <= 3) begin
                    vm[j] = 1'b1;
                    d[31-8*j -: 8] = v.base + 8'(16*rr + j);
                end
            end
            if (v.overrun && t == 6) begin
                vm[2] = 1'b1;
                d[23:16] = 8'hEE;
            end
            bus.OCOL_VALID = vm;
            bus.OROW_i     = d;
            tick();
        end
        bus.OCOL_VALID = 4'd0;
        bus.OROW_i     = 32'd0;
        bus.ODST_i     = ~v.dst;
    endtask

    task automatic drain(input vec_t v, output int dones);
        bit stalled  = 0;
        bit intruded = 0;
        dones = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (bus.DONE === 1'b1) dones++;
            if (!stalled && v.stall_len > 0 && bus.OVALID === 1'b1 && bus.OADDR == 2'(v.stall_row)) begin
                stalled = 1;
                bus.OREADY = 1'b0;
                for (int k = 0; k < v.stall_len; k++) begin
                    check("stall_hold", {29'd0, bus.OVALID, bus.OADDR, bus.OWord},
                          {29'd0, 1'b1, 2'(v.stall_row), exp_word(v.base, v.stall_row)});
                    tick();
                end
                bus.OREADY = 1'b1;
                continue;
            end
            if (!intruded && v.intrude_row >= 0 && bus.OVALID === 1'b1 && bus.OADDR == 2'(v.intrude_row)) begin
                intruded = 1;
                bus.OCOL_VALID = 4'b0001;
                bus.OROW_i     = 32'hFFFF_FFFF;
                tick();
                bus.OCOL_VALID = 4'd0;
                bus.OROW_i     = 32'd0;
                continue;
            end
            tick();
        end
    endtask

    task automatic post_checks(input int dones, input logic exp_err);
        check("done_pulses", 64'(dones), 64'd1);
        check("err_flag", {63'd0, bus.ERR}, {63'd0, exp_err});
        check("rows_left", 64'(sb.size()), 64'd0);
        check("idle_after", {62'd0, bus.BUSY, bus.OVALID}, 64'd0);
    endtask

    vec_t vecs [6];
    vec_t nom;
    int   dones;
    bit   seen;

    initial begin
        vecs[0] = '{base: 8'h00, dst: 4'hA, stall_row: -1, stall_len: 0, overrun: 0, intrude_row: -1, exp_err: 1'b0};
        vecs[1] = '{base: 8'h00, dst: 4'hA, stall_row: 1,  stall_len: 5, overrun: 0, intrude_row: -1, exp_err: 1'b0};
        vecs[2] = '{base: 8'h40, dst: 4'h5, stall_row: 3,  stall_len: 2, overrun: 0, intrude_row: -1, exp_err: 1'b0};
        vecs[3] = '{base: 8'h80, dst: 4'hC, stall_row: -1, stall_len: 0, overrun: 1, intrude_row: -1, exp_err: 1'b1};
        vecs[4] = '{base: 8'h00, dst: 4'h3, stall_row: -1, stall_len: 0, overrun: 0, intrude_row: 1,  exp_err: 1'b1};
        vecs[5] = '{base: 8'h20, dst: 4'hF, stall_row: -1, stall_len: 0, overrun: 0, intrude_row: 3,  exp_err: 1'b1};
        nom = vecs[0];

        bus.OCOL_VALID = 4'd0;
        bus.OROW_i     = 32'd0;
        bus.ODST_i     = 4'd0;
        bus.OREADY     = 1'b1;
        #3;

        for (int i = 0; i < 6; i++) begin
            apply_reset();
            send_beats(vecs[i]);
            drain(vecs[i], dones);
            post_checks(dones, vecs[i].exp_err);
        end

        // Back-to-back aftermath: a fresh matrix from IDLE still drains normally.
        nom.dst = 4'h6;
        send_beats(nom);
        drain(nom, dones);
        post_checks(dones, 1'b1);

        // Stray col3 beat in IDLE.
        apply_reset();
        bus.OCOL_VALID = 4'b1000;
        bus.OROW_i     = 32'h1234_5678;
        tick();
        bus.OCOL_VALID = 4'd0;
        bus.OROW_i     = 32'd0;
        tick();
        check("idle_stray_busy_err", {61'd0, bus.BUSY, bus.OVALID, bus.ERR}, {61'd0, 1'b0, 1'b0, 1'b1});

        // Reset in the middle of DRAIN, after row 1 has been accepted.
        apply_reset();
        nom = vecs[0];
        nom.base = 8'h60;
        nom.dst  = 4'h9;
        send_beats(nom);
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            if (bus.OVALID === 1'b1 && bus.OADDR == 2'd2) seen = 1;
            else tick();
        end
        check("reach_row2", {63'd0, seen}, 64'd1);
        RSTN = 1'b0;
        #2;
        check_all_zero("mid_drain_reset");
        sb.delete();
        tick();
        RSTN = 1'b1;
        tick();
        nom = vecs[0];
        send_beats(nom);
        drain(nom, dones);
        post_checks(dones, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/obuffer4.md
OBUFFER4 -- requirements
Module: obuffer4

Interface
REQ-001 The module SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have port RSTN, input, 1 bit: asynchronous, active-low reset.
REQ-003 The module SHALL have port OCOL_VALID, input, 4 bits: per-column result valid from the MAC array; column j is skewed one cycle behind column j-1.
REQ-004 The module SHALL have port OROW_i, input, 32 bits: one result byte per column; [31:24]=col0, [23:16]=col1, [15:8]=col2, [7:0]=col3.
REQ-005 The module SHALL have port ODST_i, input, 4 bits: destination tag for the matrix being captured.
REQ-006 The module SHALL have port OREADY, input, 1 bit: downstream accepts OWord this cycle.
REQ-007 The module SHALL have port OWord, output, 32 bits: one de-skewed result row, using the same byte order as OROW_i.
REQ-008 The module SHALL have port OVALID, output, 1 bit: OWord, OADDR and ODST_o are valid.
REQ-009 The module SHALL have port OADDR, output, 2 bits: row index of the presented OWord.
REQ-010 The module SHALL have port ODST_o, output, 4 bits: tag latched for the current matrix.
REQ-011 The module SHALL have port BUSY, output, 1 bit: high whenever state is not IDLE.
REQ-012 The module SHALL have port DONE, output, 1 bit: one-cycle pulse after the last row is accepted.
REQ-013 The module SHALL have port ERR, output, 1 bit: sticky protocol-violation flag.

Function
REQ-014 The module SHALL hold a 4x4 byte matrix mem[row][col], one 2-bit row counter per column, and a 3-state FSM: IDLE, CAPTURE, DRAIN.
REQ-015 In IDLE or CAPTURE, each cycle with OCOL_VALID[j]=1 SHALL write byte lane j of OROW_i into mem[cnt_j][j] and increment cnt_j; the beats of column j arrive as rows 0,1,2,3 in order.
REQ-016 IDLE->CAPTURE SHALL occur on OCOL_VALID[0]=1; that beat is captured, and ODST_i is latched into ODST_o in the same cycle.
REQ-017 Each column SHALL accept exactly 4 beats per matrix; a column that has 4 beats marks itself full, and further OCOL_VALID[j] in CAPTURE SHALL be ignored and set ERR.
REQ-018 CAPTURE->DRAIN SHALL occur on the cycle column 3 takes its 4th beat; for normal skew this is 7 cycles after the first col0 beat (16 beats total).
REQ-019 In DRAIN, OVALID SHALL be 1 from the first DRAIN cycle, with OWord={mem[r][0],mem[r][1],mem[r][2],mem[r][3]}, OADDR=r, and r starting at 0.
REQ-020 The presented row SHALL advance only on OVALID&OREADY; OWord, OADDR and ODST_o SHALL stay stable while OREADY=0 (no drop, no repeat).
REQ-021 On the handshake of row 3, the FSM SHALL go to IDLE; DONE=1 for the next cycle only; all column counters and full flags SHALL clear.
REQ-022 Any OCOL_VALID bit set during DRAIN SHALL be ignored (mem unchanged) and SHALL set ERR.
REQ-023 OCOL_VALID[j]=1 with j>0 in IDLE SHALL be ignored and SHALL set ERR; the FSM SHALL remain in IDLE.
REQ-024 ERR SHALL be cleared only by reset.
REQ-025 Back-to-back matrices: a col0 beat in the same cycle as the row-3 handshake SHALL be treated as DRAIN-time and flagged; a new matrix starts from IDLE.
REQ-026 OVALID SHALL be 0 in IDLE and CAPTURE; OWord and OADDR are don't-care when OVALID=0 but SHALL be driven from registers.

Reset
REQ-027 RSTN=0 SHALL asynchronously force state IDLE, all counters and full flags 0, OVALID=0, OADDR=0, ODST_o=0, BUSY=0, DONE=0, ERR=0, OWord=0, and all mem bytes 0.
REQ-028 Reset asserted mid-CAPTURE or mid-DRAIN SHALL abandon the matrix; after release the module SHALL be in IDLE and accept a new matrix normally.

Verification
REQ-029 Nominal: skewed 16 beats with byte = 0x10*row+col, ODST_i=0xA, OREADY=1 -> OWord sequence 0x00010203, 0x10111213, 0x20212223, 0x30313233 with OADDR 0-3, ODST_o=0xA, DONE pulses once, ERR=0.
REQ-030 Backpressure: OREADY=0 for 5 cycles during row 1 -> OWord holds 0x10111213 with OVALID=1; each row is emitted exactly once.
REQ-031 Overrun: a 5th OCOL_VALID[2] beat during CAPTURE -> mem unchanged, ERR=1, output rows still match the first 4 beats.
REQ-032 DRAIN intrusion: OCOL_VALID=4'b0001 during DRAIN -> ERR=1, output data unchanged, FSM returns to IDLE after row 3.
REQ-033 Reset mid-DRAIN after row 1: RSTN pulse -> all outputs 0; a following nominal matrix drains correctly starting at OADDR=0.
REQ-034 Stray col3 beat in IDLE -> BUSY stays 0, ERR=1.
